// File: rtl/booth_mul_arbiter_pkg.sv
// Shared types and defaults for the Booth multiplier arbiter: FSM state encoding,
// default latency mask and timeout, and the timeout counter width helper.
package booth_mul_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int DEF_MIN_LAT = 1;
  localparam int DEF_TIMEOUT = 15;

  // The counter only has to reach TIMEOUT, so TIMEOUT=15 fits in 4 bits.
  function automatic int cnt_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/booth_mul_arbiter_if.sv
// Requester-side bus of the multiplier arbiter: per-requester request/operands,
// one-hot accept strobes and the shared response bus.
interface booth_mul_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [15:0]       rsp_data;
  logic              rsp_err;
  logic [NREQ-1:0]   rsp_ready;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/booth_mul_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping around; returns a one-hot grant and the matching index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  index
);

  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    index = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        index      = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one Booth multiplier between NREQ requesters: round-robin accept, one
// start pulse, masked/timed wait for the result, then a held response.
module booth_mul_arbiter
  import booth_mul_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int MIN_LAT = DEF_MIN_LAT,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  booth_mul_arbiter_if.slave   bus,
  output logic                 mul_en,
  output logic [7:0]           mul_a,
  output logic [7:0]           mul_b,
  input  logic [15:0]          mul_result,
  input  logic                 mul_rdy,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id
);

  localparam int CW = cnt_width(TIMEOUT);

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d, gid_d, pick;
  logic [NREQ-1:0] grant;
  logic [7:0]      a_d, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     data_d;
  logic            err_d;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .index (pick)
  );

  assign mul_en        = (state_q == ST_ISSUE);
  assign busy          = (state_q != ST_IDLE);
  // Gated by rst_n so no accept strobe is visible while reset is held.
  assign bus.req_ready = (state_q == ST_IDLE && rst_n) ? grant : '0;
  assign bus.rsp_valid = (state_q == ST_RESP) ? (NREQ'(1) << grant_id) : '0;

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no branch can leave one unassigned and infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = grant_id;
    a_d     = mul_a;
    b_d     = mul_b;
    cnt_d   = cnt_q;
    data_d  = bus.rsp_data;
    err_d   = bus.rsp_err;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          a_d     = bus.req_a[8*int'(pick) +: 8];
          b_d     = bus.req_b[8*int'(pick) +: 8];
          gid_d   = pick;
          ptr_d   = IDW'((int'(pick) + 1) % NREQ);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A ready in the masked window may be left over from the previous operation.
        if (cnt_q >= CW'(MIN_LAT) && mul_rdy) begin
          data_d  = mul_result;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready[grant_id]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      grant_id     <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      cnt_q        <= '0;
      bus.rsp_data <= '0;
      bus.rsp_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_id     <= gid_d;
      mul_a        <= a_d;
      mul_b        <= b_d;
      cnt_q        <= cnt_d;
      bus.rsp_data <= data_d;
      bus.rsp_err  <= err_d;
    end
  end

endmodule
